// File: rtl/sys_time_mod_scheduler_pkg.sv
// Shared types for the system-time modulo scheduler: FSM states, the
// in-flight tag carried alongside the divider pipeline, and index sizing.
package sys_time_mod_scheduler_pkg;

  localparam int N_REQ_DEFAULT = 3;
  localparam int DIVISOR_W     = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag fields are sized for the default requester count and the divider's
  // native divisor width; N_REQ must fit in TAG_IDX_W bits.
  localparam int TAG_IDX_W = idx_w(N_REQ_DEFAULT);

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
    logic [DIVISOR_W-1:0] divisor;
  } tag_t;

endpackage

// File: rtl/sys_time_mod_scheduler_if.sv
// Link between the scheduler and the shared pipelined remainder divider.
interface sys_time_mod_scheduler_if #(
  parameter int WIDTH = 16
);
  // DIV_TVALID is a one-cycle issue strobe with no back-pressure: the divider
  // accepts every issue and raises DIV_REM_VALID exactly DIV_LATENCY clocks later.
  logic [63:0]      DIV_DIVIDEND;
  logic [WIDTH-1:0] DIV_DIVISOR;
  logic             DIV_TVALID;
  logic [WIDTH-1:0] DIV_REM;
  logic             DIV_REM_VALID;

  modport master (
    output DIV_DIVIDEND, DIV_DIVISOR, DIV_TVALID,
    input  DIV_REM, DIV_REM_VALID
  );

  modport slave (
    input  DIV_DIVIDEND, DIV_DIVISOR, DIV_TVALID,
    output DIV_REM, DIV_REM_VALID
  );
endinterface

// File: rtl/sys_time_mod_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after PTR.
module sys_time_mod_scheduler_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  ELIGIBLE,
  input  logic [IW-1:0] PTR,
  output logic          GRANT_VALID,
  output logic [IW-1:0] GRANT_IDX
);
  int j;

  // Scan from the farthest offset down so the closest hit to PTR wins.
  always_comb begin
    GRANT_VALID = 1'b0;
    GRANT_IDX   = '0;
    j           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(PTR) + k;
      if (j >= N) j = j - N;
      if (ELIGIBLE[j]) begin
        GRANT_VALID = 1'b1;
        GRANT_IDX   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sys_time_mod_scheduler.sv
// Shares one pipelined 64/16 remainder divider among N_REQ requesters that each
// need ((SYS_TIME + LEAD) >> SHIFT) mod CYCLE; results return by tag pipeline.
module sys_time_mod_scheduler
  import sys_time_mod_scheduler_pkg::*;
#(
  parameter int          N_REQ       = 3,
  parameter int          WIDTH       = 16,
  parameter int          DIV_LATENCY = 67,
  parameter int          SHIFT       = 2,
  parameter logic [63:0] LEAD        = 64'd0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [63:0]            SYS_TIME,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] CYCLE,
  output logic [N_REQ*WIDTH-1:0] REM,
  output logic [N_REQ-1:0]       REM_VALID,
  output logic [N_REQ-1:0]       BUSY,
  output logic                   ERR,
  output state_t                 DBG_STATE,
  sys_time_mod_scheduler_if.master div
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(DIV_LATENCY + 1);

  logic [WIDTH-1:0] cyc   [N_REQ];
  logic [WIDTH-1:0] rem_q [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cyc[g]                   = CYCLE[g*WIDTH +: WIDTH];
    assign REM[g*WIDTH +: WIDTH]    = rem_q[g];
  end

  state_t        state, state_nxt;
  logic [CW-1:0] flush_cnt, flush_cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= FLUSH;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // FLUSH outlasts the divider latency so stale results from an un-reset
  // divider drain out before any tag can be expected.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      FLUSH: begin
        if (flush_cnt == CW'(DIV_LATENCY)) begin
          state_nxt     = RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + CW'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = FLUSH;
    endcase
  end

  logic [N_REQ-1:0] busy_q, rem_vld_q, eligible;
  logic [IW-1:0]    ptr_q, grant_idx;
  logic             grant_valid, err_q;
  logic [63:0]      dividend_q;
  logic [WIDTH-1:0] divisor_q;
  tag_t             issue_q;
  tag_t             pipe_q [DIV_LATENCY];
  tag_t             tail;
  logic [IW-1:0]    tail_idx;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = (state == RUN) && REQ[i] && !busy_q[i] && (cyc[i] != '0);
  end

  sys_time_mod_scheduler_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .ELIGIBLE    (eligible),
    .PTR         (ptr_q),
    .GRANT_VALID (grant_valid),
    .GRANT_IDX   (grant_idx)
  );

  assign tail     = pipe_q[DIV_LATENCY-1];
  assign tail_idx = tail.idx[IW-1:0];

  logic ret_clear, ret_accept, err_set;

  // A changed (or zeroed) CYCLE makes the stored divisor mismatch, so the
  // stale remainder is dropped but the requester is still released.
  always_comb begin
    ret_clear  = 1'b0;
    ret_accept = 1'b0;
    err_set    = 1'b0;
    if (state == RUN) begin
      if (tail.valid) begin
        ret_clear = 1'b1;
        if (div.DIV_REM_VALID)
          ret_accept = (tail.divisor == DIVISOR_W'(cyc[tail_idx]));
        else
          err_set = 1'b1;
      end else if (div.DIV_REM_VALID) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q      <= '0;
      busy_q     <= '0;
      rem_vld_q  <= '0;
      err_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      issue_q    <= '0;
      for (int i = 0; i < N_REQ; i++)       rem_q[i]  <= '0;
      for (int k = 0; k < DIV_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      rem_vld_q <= '0;
      issue_q   <= '0;
      pipe_q[0] <= issue_q;
      for (int k = 1; k < DIV_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
      if (grant_valid) begin
        ptr_q      <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
        dividend_q <= (SYS_TIME + LEAD) >> SHIFT;
        divisor_q  <= cyc[grant_idx];
        issue_q    <= '{valid: 1'b1, idx: TAG_IDX_W'(grant_idx),
                        divisor: DIVISOR_W'(cyc[grant_idx])};
        busy_q[grant_idx] <= 1'b1;
      end
      // BUSY is still set on the return cycle, so grant and clear never share an index.
      if (ret_clear) busy_q[tail_idx] <= 1'b0;
      if (ret_accept) begin
        rem_q[tail_idx]     <= div.DIV_REM;
        rem_vld_q[tail_idx] <= 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign div.DIV_DIVIDEND = dividend_q;
  assign div.DIV_DIVISOR  = divisor_q;
  assign div.DIV_TVALID   = issue_q.valid;
  assign REM_VALID        = rem_vld_q;
  assign BUSY             = busy_q;
  assign ERR              = err_q;
  assign DBG_STATE        = state;

endmodule
